// File: rtl/ubasr_ini.sv
// UBA status register: sticky TMO/NXD error bits, DXF/PIH/PIL fields, a counted
// INI one-shot that resets the fields, and PI request mapping of device BR lines.
module ubasr_ini #(
    parameter int NDEV        = 5,
    parameter int INI_CYCLES  = 50,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:35]           busDATAI,
    input  logic [1:NDEV]         devACLO,
    input  logic [1:NDEV][7:4]    devINTR,
    input  logic                  statWRITE,
    input  logic                  setTMO,
    input  logic                  setNXD,
    output logic [0:35]           regUBASR,
    output logic                  ubaINIT,
    output logic [1:7]            piREQ
);

    localparam int CW = $clog2(INI_CYCLES + 1);

    logic            tmo, nxd, dxf, hi, lo;
    logic [2:0]      pih, pil;
    logic [CW-1:0]   iniCnt;
    logic [NDEV-1:0] aclo [SYNC_STAGES];

    logic iniActive, iniWrite, wTmo, wNxd, setT, setN, hiNext, loNext, pwr;
    logic unusedBits;

    assign iniActive = (iniCnt != '0);
    assign iniWrite  = statWRITE & busDATAI[29];
    assign wTmo      = statWRITE & busDATAI[18];
    assign wNxd      = statWRITE & busDATAI[21];
    assign setT      = (setTMO | setNXD) & ~iniActive;
    assign setN      = setNXD & ~iniActive;
    assign pwr       = |aclo[SYNC_STAGES-1];
    assign ubaINIT   = iniActive;
    assign unusedBits = ^{busDATAI[0:17], busDATAI[19:20], busDATAI[22:27]};

    always_comb begin
        hiNext = 1'b0;
        loNext = 1'b0;
        for (int unsigned d = 1; d <= NDEV; d++) begin
            hiNext = hiNext | devINTR[d][7] | devINTR[d][6];
            loNext = loNext | devINTR[d][5] | devINTR[d][4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo    <= 1'b0;
            nxd    <= 1'b0;
            dxf    <= 1'b0;
            pih    <= '0;
            pil    <= '0;
            hi     <= 1'b0;
            lo     <= 1'b0;
            iniCnt <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) aclo[i] <= '0;
        end else begin
            hi      <= hiNext;
            lo      <= loNext;
            aclo[0] <= devACLO;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) aclo[i] <= aclo[i-1];

            if (iniWrite)       iniCnt <= CW'(INI_CYCLES);
            else if (iniActive) iniCnt <= iniCnt - 1'b1;

            // INI clear wins over everything; otherwise a write-1 clear beats a set
            if (iniWrite) begin
                tmo <= 1'b0;
                nxd <= 1'b0;
                dxf <= 1'b0;
                pih <= '0;
                pil <= '0;
            end else begin
                tmo <= (tmo | setT) & ~wTmo;
                nxd <= (nxd | setN) & ~wNxd;
                if (statWRITE) begin
                    dxf <= busDATAI[28];
                    pih <= busDATAI[30:32];
                    pil <= busDATAI[33:35];
                end
            end
        end
    end

    always_comb begin
        regUBASR        = '0;
        regUBASR[18]    = tmo;
        regUBASR[21]    = nxd;
        regUBASR[24]    = hi;
        regUBASR[25]    = lo;
        regUBASR[26]    = pwr;
        regUBASR[28]    = dxf;
        regUBASR[29]    = iniActive;
        regUBASR[30:32] = pih;
        regUBASR[33:35] = pil;
    end

    always_comb begin
        piREQ = '0;
        for (int unsigned lvl = 1; lvl <= 7; lvl++) begin
            if (!iniActive)
                piREQ[lvl] = (hi && (pih == 3'(lvl))) || (lo && (pil == 3'(lvl)));
        end
    end

endmodule

// File: tb/tb_ubasr_ini.sv
// Directed bench for ubasr_ini: stimulus pushes expected state into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_ubasr_ini;

    localparam int NDEV = 5;
    localparam int INI_CYCLES = 50;
    localparam int SYNC_STAGES = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [0:35]         busDATAI;
    logic [1:NDEV]       devACLO;
    logic [1:NDEV][7:4]  devINTR;
    logic                statWRITE, setTMO, setNXD;
    logic [0:35]         regUBASR;
    logic                ubaINIT;
    logic [1:7]          piREQ;

    ubasr_ini #(.NDEV(NDEV), .INI_CYCLES(INI_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .busDATAI(busDATAI), .devACLO(devACLO), .devINTR(devINTR),
        .statWRITE(statWRITE), .setTMO(setTMO), .setNXD(setNXD),
        .regUBASR(regUBASR), .ubaINIT(ubaINIT), .piREQ(piREQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [0:35] r;
        logic        i;
        logic [1:7]  p;
    } exp_t;

    exp_t expQ[$];
    int   nVec = 0;
    int   nBad = 0;

    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            nVec++;
            if (regUBASR !== e.r || ubaINIT !== e.i || piREQ !== e.p) begin
                nBad++;
                $display("FAIL %s: got reg=%h init=%b pi=%b, want reg=%h init=%b pi=%b",
                         e.name, regUBASR, ubaINIT, piREQ, e.r, e.i, e.p);
            end
        end
    end

    function automatic logic [0:35] mk(input logic tmo, input logic nxd, input logic hi,
                                       input logic lo, input logic pwr, input logic dxf,
                                       input logic ini, input logic [2:0] pih,
                                       input logic [2:0] pil);
        logic [0:35] r;
        r = '0;
        r[18] = tmo; r[21] = nxd; r[24] = hi; r[25] = lo; r[26] = pwr;
        r[28] = dxf; r[29] = ini; r[30:32] = pih; r[33:35] = pil;
        return r;
    endfunction

    function automatic logic [1:7] pl(input int a, input int b);
        logic [1:7] p;
        p = '0;
        if (a != 0) p[a] = 1'b1;
        if (b != 0) p[b] = 1'b1;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [0:35] r, input logic i,
                       input logic [1:7] p);
        exp_t e;
        e.name = name; e.r = r; e.i = i; e.p = p;
        expQ.push_back(e);
    endtask

    task automatic wr(input logic [0:35] d);
        busDATAI = d;
        statWRITE = 1'b1;
        tick();
        statWRITE = 1'b0;
        busDATAI = '0;
    endtask

    initial begin
        int rem;
        logic [2:0] pihE;
        rst = 1'b1; busDATAI = '0; devACLO = '0; devINTR = '0;
        statWRITE = 1'b0; setTMO = 1'b0; setNXD = 1'b0;
        #1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset", '0, 1'b0, '0);

        // sticky W1C
        setNXD = 1'b1; tick(); setNXD = 1'b0;
        chk("setNXD", mk(1,1,0,0,0,0,0,0,0), 1'b0, '0);
        wr(mk(0,1,0,0,0,0,0,0,0));
        chk("clrNXD", mk(1,0,0,0,0,0,0,0,0), 1'b0, '0);
        setTMO = 1'b1; wr(mk(1,0,0,0,0,0,0,0,0)); setTMO = 1'b0;
        chk("clrBeatsSet", '0, 1'b0, '0);
        setTMO = 1'b1; wr('0); setTMO = 1'b0;
        chk("write0KeepsSet", mk(1,0,0,0,0,0,0,0,0), 1'b0, '0);
        wr(mk(1,0,0,0,0,0,0,0,0));
        chk("clrTMO", '0, 1'b0, '0);

        // PI mapping
        wr(mk(0,0,0,0,0,1,0,3,5));
        chk("loadFields", mk(0,0,0,0,0,1,0,3,5), 1'b0, '0);
        devINTR[2][6] = 1'b1;
        chk("hiLatency", mk(0,0,0,0,0,1,0,3,5), 1'b0, '0);
        tick();
        chk("hiPI3", mk(0,0,1,0,0,1,0,3,5), 1'b0, pl(3,0));
        devINTR[4][4] = 1'b1;
        tick();
        chk("loPI5", mk(0,0,1,1,0,1,0,3,5), 1'b0, pl(3,5));
        wr(mk(0,0,0,0,0,1,0,0,5));
        chk("pih0", mk(0,0,1,1,0,1,0,0,5), 1'b0, pl(5,0));
        wr(mk(0,0,0,0,0,1,0,5,5));
        chk("sameLevel", mk(0,0,1,1,0,1,0,5,5), 1'b0, pl(5,0));
        wr(mk(0,0,0,0,0,1,0,3,5));
        setTMO = 1'b1; tick(); setTMO = 1'b0;
        chk("preIni", mk(1,0,1,1,0,1,0,3,5), 1'b0, pl(3,5));

        // INI pulse with retrigger at cycle 30, ignored setTMO at 10, write at 40
        setNXD = 1'b1; wr(mk(0,0,0,0,0,1,1,7,7)); setNXD = 1'b0;
        rem = INI_CYCLES;
        pihE = 3'd0;
        chk("iniStart", mk(0,0,1,1,0,0,1,0,0), 1'b1, '0);
        for (int k = 1; k <= 85; k++) begin
            if (k == 10) setTMO = 1'b1;
            if (k == 30) begin busDATAI = mk(0,0,0,0,0,0,1,0,0); statWRITE = 1'b1; end
            if (k == 40) begin busDATAI = mk(0,0,0,0,0,0,0,3,0); statWRITE = 1'b1; end
            tick();
            setTMO = 1'b0; statWRITE = 1'b0; busDATAI = '0;
            if (k == 30) rem = INI_CYCLES;
            else if (rem > 0) rem--;
            if (k == 40) pihE = 3'd3;
            chk($sformatf("ini_k%0d", k), mk(0,0,1,1,0,0,rem != 0,pihE,0), rem != 0,
                (rem == 0 && pihE == 3'd3) ? pl(3,0) : '0);
        end

        // power-fail synchronizer
        devACLO[NDEV] = 1'b1;
        tick();
        chk("pwrSync1", mk(0,0,1,1,0,0,0,3,0), 1'b0, pl(3,0));
        tick();
        chk("pwrSet", mk(0,0,1,1,1,0,0,3,0), 1'b0, pl(3,0));
        devACLO[NDEV] = 1'b0;
        tick();
        chk("pwrHold", mk(0,0,1,1,1,0,0,3,0), 1'b0, pl(3,0));
        tick();
        chk("pwrClr", mk(0,0,1,1,0,0,0,3,0), 1'b0, pl(3,0));

        // reset in the middle of INI
        wr(mk(0,0,0,0,0,0,1,0,0));
        repeat (19) tick();
        chk("iniAt20", mk(0,0,1,1,0,0,1,0,0), 1'b1, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstMidIni", '0, 1'b0, '0);
        tick();
        chk("postRst", mk(0,0,1,1,0,0,0,0,0), 1'b0, '0);

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            nBad++;
            $display("FAIL drain: got %0d pending, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
